// File: rtl/pts_seq_pkg.sv
// rtl/pts_seq_pkg.sv - shared types and helpers for the chunk sequencer
// Purpose: FSM state type and the chunk-count helper used to size the counter.
package pts_seq_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } pts_seq_state_t;

    // Number of output chunks carved out of one input word.
    function automatic int chunks(input int num_in, input int num_out);
        return num_in / num_out;
    endfunction

endpackage

// File: rtl/pts_chunk_sequencer_if.sv
// rtl/pts_chunk_sequencer_if.sv - word-in / chunk-out handshake bundle
// Purpose: groups the input word stream and output chunk stream.
//   in_data/in_valid/in_ready      : word stream into the sequencer
//   out_data/out_valid/out_ready   : chunk stream out of the sequencer
//   out_last                       : marks the final chunk of a word
// master = producer/consumer side, slave = sequencer side.
interface pts_chunk_sequencer_if #(
    parameter int NUM_BYTES_IN  = 4,
    parameter int NUM_BYTES_OUT = 1
) ();
    logic [NUM_BYTES_IN*8-1:0]  in_data;
    logic                       in_valid;
    logic                       in_ready;
    logic [NUM_BYTES_OUT*8-1:0] out_data;
    logic                       out_valid;
    logic                       out_ready;
    logic                       out_last;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_last
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_last
    );
endinterface

// File: rtl/flexbyte_pts_sr.sv
// rtl/flexbyte_pts_sr.sv - multibyte parallel-to-serial shift register
// Purpose: parallel load of a word, then shift out NUM_BYTES_OUT bytes per step.
// Ports:
//   clk             clock
//   n_rst           async active-low reset, clears the register
//   i_load_enable   load i_parallel_in (wins over shift)
//   i_shift_enable  advance to the next chunk
//   i_parallel_in   word to load
//   o_serial_out    current chunk (top chunk when MSB=1, bottom chunk when MSB=0)
module flexbyte_pts_sr #(
    parameter int MSB           = 1,
    parameter int NUM_BYTES_IN  = 4,
    parameter int NUM_BYTES_OUT = 1
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       i_load_enable,
    input  logic                       i_shift_enable,
    input  logic [NUM_BYTES_IN*8-1:0]  i_parallel_in,
    output logic [NUM_BYTES_OUT*8-1:0] o_serial_out
);
    localparam int IW = NUM_BYTES_IN * 8;
    localparam int OW = NUM_BYTES_OUT * 8;

    logic [IW-1:0] r_sr;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_sr <= '0;
        end else if (i_load_enable) begin
            r_sr <= i_parallel_in;
        end else if (i_shift_enable) begin
            r_sr <= (MSB != 0) ? (r_sr << OW) : (r_sr >> OW);
        end
    end

    generate
        if (MSB != 0) begin : g_msb
            assign o_serial_out = r_sr[IW-1 -: OW];
        end else begin : g_lsb
            assign o_serial_out = r_sr[OW-1:0];
        end
    endgenerate
endmodule

// File: rtl/pts_chunk_sequencer.sv
// rtl/pts_chunk_sequencer.sv - transmit-side sequencer around flexbyte_pts_sr
// Purpose: accepts words, buffers one in a holding register, loads the shift
// register and presents each chunk with valid/ready and a last marker.
// Ports:
//   clk      clock
//   rst      async active-high reset
//   bus      word-in / chunk-out handshakes (slave modport)
//   i_abort  synchronous flush of all pending data
//   o_busy   a word is being emitted or waiting in the holding register
module pts_chunk_sequencer
    import pts_seq_pkg::*;
#(
    parameter int MSB           = 1,
    parameter int NUM_BYTES_IN  = 4,
    parameter int NUM_BYTES_OUT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    pts_chunk_sequencer_if.slave  bus,
    input  logic                  i_abort,
    output logic                  o_busy
);
    localparam int CHUNKS = chunks(NUM_BYTES_IN, NUM_BYTES_OUT);
    localparam int CW     = (CHUNKS < 2) ? 1 : $clog2(CHUNKS);
    localparam logic [CW-1:0] LAST_CNT = CW'(CHUNKS - 1);

    generate
        if ((NUM_BYTES_IN % NUM_BYTES_OUT) != 0 || CHUNKS < 2) begin : g_bad_cfg
            $fatal(1, "pts_chunk_sequencer: NUM_BYTES_IN must be a multiple (>=2x) of NUM_BYTES_OUT");
        end
    endgenerate

    pts_seq_state_t            r_state;
    pts_seq_state_t            w_state_nxt;
    logic [CW-1:0]             r_cnt;
    logic [CW-1:0]             w_cnt_nxt;
    logic [NUM_BYTES_IN*8-1:0] r_hold_data;
    logic                      r_hold_valid;
    logic                      w_accept;
    logic                      w_hs;
    logic                      w_load;
    logic                      w_shift;
    logic                      w_n_rst;

    assign bus.in_ready  = ~r_hold_valid & ~i_abort;
    assign w_accept      = bus.in_valid & bus.in_ready;
    assign bus.out_valid = (r_state == ACTIVE);
    assign bus.out_last  = (r_state == ACTIVE) && (r_cnt == LAST_CNT);
    assign w_hs          = (r_state == ACTIVE) & bus.out_ready;
    assign o_busy        = (r_state == ACTIVE) | r_hold_valid;
    assign w_n_rst       = ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Abort overrides everything; otherwise the final-chunk handshake either
    // reloads straight from the holding register (no idle gap) or goes idle.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        if (i_abort) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (r_hold_valid) begin
                        w_load      = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (w_hs) begin
                        if (r_cnt != LAST_CNT) begin
                            w_shift   = 1'b1;
                            w_cnt_nxt = r_cnt + 1'b1;
                        end else if (r_hold_valid) begin
                            w_load    = 1'b1;
                            w_cnt_nxt = '0;
                        end else begin
                            w_state_nxt = IDLE;
                            w_cnt_nxt   = '0;
                        end
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Accept and load never coincide: accept needs the hold empty, load needs it full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_data  <= '0;
            r_hold_valid <= 1'b0;
        end else if (i_abort) begin
            r_hold_valid <= 1'b0;
        end else if (w_accept) begin
            r_hold_data  <= bus.in_data;
            r_hold_valid <= 1'b1;
        end else if (w_load) begin
            r_hold_valid <= 1'b0;
        end
    end

    flexbyte_pts_sr #(
        .MSB           (MSB),
        .NUM_BYTES_IN  (NUM_BYTES_IN),
        .NUM_BYTES_OUT (NUM_BYTES_OUT)
    ) u_sr (
        .clk            (clk),
        .n_rst          (w_n_rst),
        .i_load_enable  (w_load),
        .i_shift_enable (w_shift),
        .i_parallel_in  (r_hold_data),
        .o_serial_out   (bus.out_data)
    );
endmodule

// File: tb/tb_pts_chunk_sequencer.sv
// tb/tb_pts_chunk_sequencer.sv - self-checking bench for pts_chunk_sequencer
module tb_pts_chunk_sequencer;
    localparam int CHUNKS = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic abort;
    logic busy0, busy1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   both_cnt = 0;

    typedef struct {
        logic [7:0] data;
        logic       last;
        int         cyc;
    } chunk_t;

    chunk_t mon0[$];
    chunk_t mon1[$];

    always #5 clk = ~clk;

    pts_chunk_sequencer_if #(.NUM_BYTES_IN(4), .NUM_BYTES_OUT(1)) bus0 ();
    pts_chunk_sequencer_if #(.NUM_BYTES_IN(4), .NUM_BYTES_OUT(1)) bus1 ();

    assign bus1.in_data   = bus0.in_data;
    assign bus1.in_valid  = bus0.in_valid;
    assign bus1.out_ready = bus0.out_ready;

    pts_chunk_sequencer #(.MSB(1), .NUM_BYTES_IN(4), .NUM_BYTES_OUT(1)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0), .i_abort(abort), .o_busy(busy0)
    );
    pts_chunk_sequencer #(.MSB(0), .NUM_BYTES_IN(4), .NUM_BYTES_OUT(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1), .i_abort(abort), .o_busy(busy1)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus0.out_valid && bus0.out_ready)
            mon0.push_back(chunk_t'{bus0.out_data, bus0.out_last, cyc});
        if (bus1.out_valid && bus1.out_ready)
            mon1.push_back(chunk_t'{bus1.out_data, bus1.out_last, cyc});
        if ((dut0.w_load && dut0.w_shift) || (dut1.w_load && dut1.w_shift))
            both_cnt <= both_cnt + 1;
    end

    // Reference: chunk i of a word, most- or least-significant byte first.
    function automatic logic [7:0] chunk_of(input logic [31:0] w, input int i, input bit msb);
        int k;
        k = msb ? (CHUNKS - 1 - i) : i;
        return w[8*k +: 8];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w, output int stalls, output int acc_cyc);
        bus0.in_data  = w;
        bus0.in_valid = 1'b1;
        stalls  = 0;
        acc_cyc = -1;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (bus0.in_ready) begin
                acc_cyc = cyc;
                tick();
                return;
            end
            stalls++;
            tick();
        end
        checks++; errors++;
        $display("FAIL send_word_timeout word=%h in_ready=%0b required 1", w, bus0.in_ready);
    endtask

    task automatic wait_idle(input int max);
        for (int i = 0; i < max; i++) begin
            if (!busy0 && !bus0.out_valid) return;
            tick();
        end
        checks++; errors++;
        $display("FAIL wait_idle_timeout busy=%0b required 0", busy0);
    endtask

    task automatic test_reset();
        abort = 1'b0;
        bus0.in_data = '0; bus0.in_valid = 1'b0; bus0.out_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus0.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus0.in_ready); end
        checks++; if (bus0.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus0.out_valid); end
        checks++; if (bus0.out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b want 0", bus0.out_last); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy0); end
        checks++; if (bus0.out_data !== 8'h00 || bus1.out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h/%h want 00", bus0.out_data, bus1.out_data); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        int st, n;
        logic [31:0] w;
        w = 32'hA1B2C3D4;
        mon0.delete(); mon1.delete();
        bus0.out_ready = 1'b1;
        send_word(w, st, n);
        bus0.in_valid = 1'b0;
        wait_idle(20);
        checks++; if (mon0.size() != CHUNKS) begin errors++; $display("FAIL single_count got %0d want %0d", mon0.size(), CHUNKS); end
        for (int i = 0; i < CHUNKS; i++) begin
            checks++;
            if (i >= mon0.size() || mon0[i].data !== chunk_of(w, i, 1) || mon0[i].last !== (i == CHUNKS-1) || mon0[i].cyc != n + 2 + i) begin
                errors++;
                $display("FAIL single_chunk%0d got %h last=%b cyc=%0d want %h last=%b cyc=%0d", i,
                         (i < mon0.size()) ? mon0[i].data : 8'hxx, (i < mon0.size()) ? mon0[i].last : 1'bx,
                         (i < mon0.size()) ? mon0[i].cyc : -1, chunk_of(w, i, 1), (i == CHUNKS-1), n + 2 + i);
            end
        end
        checks++; if (busy0 !== 1'b0 || bus0.out_valid !== 1'b0) begin errors++; $display("FAIL single_idle busy=%b valid=%b want 0 0", busy0, bus0.out_valid); end
    endtask

    task automatic test_back_to_back();
        int st1, st2, n1, n2;
        logic [31:0] w[2];
        w[0] = 32'h01020304; w[1] = 32'h05060708;
        mon0.delete(); mon1.delete();
        bus0.out_ready = 1'b1;
        send_word(w[0], st1, n1);
        send_word(w[1], st2, n2);
        bus0.in_valid = 1'b0;
        wait_idle(30);
        checks++; if (st2 == 0) begin errors++; $display("FAIL b2b_in_ready_low stalls got 0 want >0"); end
        checks++; if (mon0.size() != 2*CHUNKS) begin errors++; $display("FAIL b2b_count got %0d want %0d", mon0.size(), 2*CHUNKS); end
        for (int i = 0; i < 2*CHUNKS; i++) begin
            checks++;
            if (i >= mon0.size() || mon0[i].data !== chunk_of(w[i/CHUNKS], i%CHUNKS, 1) ||
                mon0[i].last !== ((i%CHUNKS) == CHUNKS-1) || mon0[i].cyc != n1 + 2 + i) begin
                errors++;
                $display("FAIL b2b_chunk%0d got %h cyc=%0d want %h cyc=%0d", i,
                         (i < mon0.size()) ? mon0[i].data : 8'hxx, (i < mon0.size()) ? mon0[i].cyc : -1,
                         chunk_of(w[i/CHUNKS], i%CHUNKS, 1), n1 + 2 + i);
            end
        end
    endtask

    task automatic test_stall();
        int st, n;
        logic pat[9];
        logic [31:0] w;
        w = 32'hDEADBEEF;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        mon0.delete(); mon1.delete();
        bus0.out_ready = 1'b1;
        send_word(w, st, n);
        bus0.in_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            bus0.out_ready = pat[i];
            #1;
            if (i == 1 || i == 2 || i == 3) begin
                checks++;
                if (bus0.out_valid !== 1'b1 || bus0.out_data !== 8'hDE) begin
                    errors++; $display("FAIL stall_hold_de step%0d got v=%b %h want v=1 de", i, bus0.out_valid, bus0.out_data);
                end
            end
            if (i == 4 || i == 5) begin
                checks++;
                if (bus0.out_valid !== 1'b1 || bus0.out_data !== 8'hAD || bus0.out_last !== 1'b0) begin
                    errors++; $display("FAIL stall_hold_ad step%0d got v=%b %h last=%b want v=1 ad last=0", i, bus0.out_valid, bus0.out_data, bus0.out_last);
                end
            end
            tick();
        end
        wait_idle(10);
        checks++; if (mon0.size() != CHUNKS) begin errors++; $display("FAIL stall_count got %0d want %0d", mon0.size(), CHUNKS); end
        for (int i = 0; i < CHUNKS; i++) begin
            checks++;
            if (i >= mon0.size() || mon0[i].data !== chunk_of(w, i, 1) || mon0[i].last !== (i == CHUNKS-1)) begin
                errors++; $display("FAIL stall_chunk%0d got %h want %h", i, (i < mon0.size()) ? mon0[i].data : 8'hxx, chunk_of(w, i, 1));
            end
        end
    endtask

    task automatic test_msb0();
        int st, n;
        logic [31:0] w;
        w = 32'hA1B2C3D4;
        mon0.delete(); mon1.delete();
        bus0.out_ready = 1'b1;
        send_word(w, st, n);
        bus0.in_valid = 1'b0;
        wait_idle(20);
        checks++; if (mon1.size() != CHUNKS) begin errors++; $display("FAIL msb0_count got %0d want %0d", mon1.size(), CHUNKS); end
        for (int i = 0; i < CHUNKS; i++) begin
            checks++;
            if (i >= mon1.size() || mon1[i].data !== chunk_of(w, i, 0) || mon1[i].last !== (i == CHUNKS-1) || mon1[i].cyc != n + 2 + i) begin
                errors++; $display("FAIL msb0_chunk%0d got %h want %h", i, (i < mon1.size()) ? mon1[i].data : 8'hxx, chunk_of(w, i, 0));
            end
        end
    endtask

    task automatic test_abort();
        int st, n;
        logic [31:0] w;
        bus0.out_ready = 1'b0;
        send_word(32'h11223344, st, n);
        bus0.in_valid = 1'b0;
        send_word(32'h55667788, st, n);
        bus0.in_valid = 1'b0;
        mon0.delete(); mon1.delete();
        bus0.out_ready = 1'b1;
        tick();
        tick();
        bus0.out_ready = 1'b0;
        abort = 1'b1;
        bus0.in_valid = 1'b1;
        bus0.in_data  = 32'hFFEEDDCC;
        #1;
        checks++; if (bus0.in_ready !== 1'b0) begin errors++; $display("FAIL abort_in_ready got %b want 0", bus0.in_ready); end
        tick();
        abort = 1'b0;
        bus0.in_valid = 1'b0;
        #1;
        checks++; if (bus0.out_valid !== 1'b0 || busy0 !== 1'b0 || bus0.out_last !== 1'b0) begin
            errors++; $display("FAIL abort_flush got v=%b busy=%b last=%b want 0 0 0", bus0.out_valid, busy0, bus0.out_last);
        end
        checks++; if (bus0.in_ready !== 1'b1) begin errors++; $display("FAIL abort_ready_after got %b want 1", bus0.in_ready); end
        checks++; if (mon0.size() != 2 || mon0[0].data !== 8'h11 || mon0[1].data !== 8'h22) begin
            errors++; $display("FAIL abort_pre_chunks got n=%0d want 2 (11,22)", mon0.size());
        end
        tick();
        mon0.delete(); mon1.delete();
        w = 32'h99AABBCC;
        bus0.out_ready = 1'b1;
        send_word(w, st, n);
        bus0.in_valid = 1'b0;
        wait_idle(20);
        checks++; if (mon0.size() != CHUNKS) begin errors++; $display("FAIL abort_next_count got %0d want %0d", mon0.size(), CHUNKS); end
        for (int i = 0; i < CHUNKS; i++) begin
            checks++;
            if (i >= mon0.size() || mon0[i].data !== chunk_of(w, i, 1) || mon0[i].last !== (i == CHUNKS-1)) begin
                errors++; $display("FAIL abort_next_chunk%0d got %h want %h", i, (i < mon0.size()) ? mon0[i].data : 8'hxx, chunk_of(w, i, 1));
            end
        end
    endtask

    task automatic test_reset_mid();
        int st, n;
        logic [31:0] w;
        bus0.out_ready = 1'b1;
        send_word(32'hCAFEF00D, st, n);
        bus0.in_valid = 1'b0;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bus0.out_valid !== 1'b0 || bus0.out_last !== 1'b0 || busy0 !== 1'b0 ||
                      bus0.in_ready !== 1'b1 || bus0.out_data !== 8'h00) begin
            errors++; $display("FAIL rst_mid got v=%b last=%b busy=%b rdy=%b data=%h want 0 0 0 1 00",
                               bus0.out_valid, bus0.out_last, busy0, bus0.in_ready, bus0.out_data);
        end
        @(posedge clk);
        #3;
        rst = 1'b0;
        tick();
        mon0.delete(); mon1.delete();
        w = 32'h13579BDF;
        send_word(w, st, n);
        bus0.in_valid = 1'b0;
        wait_idle(20);
        checks++; if (mon0.size() != CHUNKS) begin errors++; $display("FAIL rst_after_count got %0d want %0d", mon0.size(), CHUNKS); end
        for (int i = 0; i < CHUNKS; i++) begin
            checks++;
            if (i >= mon0.size() || mon0[i].data !== chunk_of(w, i, 1) || mon0[i].last !== (i == CHUNKS-1)) begin
                errors++; $display("FAIL rst_after_chunk%0d got %h want %h", i, (i < mon0.size()) ? mon0[i].data : 8'hxx, chunk_of(w, i, 1));
            end
        end
    endtask

    task automatic test_random();
        localparam int NW = 40;
        logic [31:0] sent_q[$];
        int   sent, pending, acc, stall;
        logic [7:0] prev;
        mon0.delete(); mon1.delete();
        sent = 0; pending = 0; stall = 0; prev = '0;
        bus0.in_valid = 1'b0;
        for (int c = 0; c < 3000 && !(sent == NW && !busy0 && !bus0.out_valid); c++) begin
            if (!pending && sent < NW && $urandom_range(3) != 0) begin
                bus0.in_data = $urandom;
                pending = 1;
            end
            bus0.in_valid  = (pending != 0);
            bus0.out_ready = (sent == NW) ? 1'b1 : ($urandom_range(2) != 0);
            #1;
            if (stall != 0) begin
                checks++;
                if (bus0.out_valid !== 1'b1 || bus0.out_data !== prev) begin
                    errors++; $display("FAIL rand_stall_stable got v=%b %h want v=1 %h", bus0.out_valid, bus0.out_data, prev);
                end
            end
            stall = bus0.out_valid && !bus0.out_ready;
            prev  = bus0.out_data;
            acc   = bus0.in_valid && bus0.in_ready;
            if (acc != 0) sent_q.push_back(bus0.in_data);
            tick();
            if (acc != 0) begin
                pending = 0;
                sent++;
            end
        end
        bus0.in_valid = 1'b0;
        checks++; if (sent != NW || busy0 !== 1'b0) begin errors++; $display("FAIL rand_drain sent=%0d busy=%b want %0d 0", sent, busy0, NW); end
        checks++; if (mon0.size() != NW*CHUNKS || mon1.size() != NW*CHUNKS) begin
            errors++; $display("FAIL rand_count got %0d/%0d want %0d", mon0.size(), mon1.size(), NW*CHUNKS);
        end
        for (int i = 0; i < sent_q.size() * CHUNKS; i++) begin
            checks++;
            if (i >= mon0.size() || i >= mon1.size() ||
                mon0[i].data !== chunk_of(sent_q[i/CHUNKS], i%CHUNKS, 1) ||
                mon1[i].data !== chunk_of(sent_q[i/CHUNKS], i%CHUNKS, 0) ||
                mon0[i].last !== ((i%CHUNKS) == CHUNKS-1) || mon1[i].last !== ((i%CHUNKS) == CHUNKS-1)) begin
                errors++;
                $display("FAIL rand_chunk%0d got %h/%h want %h/%h", i,
                         (i < mon0.size()) ? mon0[i].data : 8'hxx, (i < mon1.size()) ? mon1[i].data : 8'hxx,
                         chunk_of(sent_q[i/CHUNKS], i%CHUNKS, 1), chunk_of(sent_q[i/CHUNKS], i%CHUNKS, 0));
            end
        end
        checks++; if (both_cnt != 0) begin errors++; $display("FAIL load_shift_exclusive got %0d overlaps want 0", both_cnt); end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_msb0();
        test_abort();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
